// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer and control decoder for the 8-bit accumulator CPU.
// Only the phase counter and the sticky halt flag are state; every strobe decodes from them.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       halted,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       halt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t phase_reg;
  logic   halted_reg;
  logic   is_aluop;
  logic   halt_now;

  // The halting edge does not advance the phase, so a halted core sits at OP_ADDR.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else if (en && !halted_reg) begin
      if (phase_reg == OP_ADDR && opcode == OP_HLT) begin
        halted_reg <= 1'b1;
      end else begin
        phase_reg <= phase_t'(phase_reg + 3'd1);
      end
    end
  end

  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign halt_now = halted_reg || (phase_reg == OP_ADDR && opcode == OP_HLT);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halt_now) begin
      halt = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          rd = is_aluop;
        end
        ALU_OP: begin
          rd     = is_aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = is_aluop;
          ld_ac  = is_aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

  assign phase  = phase_reg;
  assign halted = halted_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized and directed checks of cpu_sequencer against a behavioural phase/halt model.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       halted;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;

  int errors = 0;
  int checks = 0;

  // Reference state: instruction phase number and halt flag.
  int m_phase = 0;
  bit m_halted = 1'b0;

  cpu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .halted (halted),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (phase=%0d op=%0d)", tag, observed, expected, m_phase, opcode);
    end
  endtask

  // Expected strobes straight from the decode table; order {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt}.
  function automatic logic [8:0] expect_strobes(int p, bit h, int op, bit z);
    bit aluop;
    bit s_sel, s_rd, s_wr, s_ir, s_inc, s_pc, s_ac, s_de, s_halt;
    aluop = (op >= 2 && op <= 5);
    if (h || (p == 4 && op == 0)) begin
      return 9'b000000001;
    end
    s_sel  = (p <= 3);
    s_rd   = (p >= 1 && p <= 3) || (p >= 5 && aluop);
    s_ir   = (p == 2 || p == 3);
    s_inc  = (p == 4) || (p == 6 && op == 1 && z);
    s_pc   = (p >= 6) && (op == 7);
    s_de   = (p >= 6) && (op == 6);
    s_wr   = (p == 7) && (op == 6);
    s_ac   = (p == 7) && aluop;
    s_halt = 1'b0;
    return {s_sel, s_rd, s_wr, s_ir, s_inc, s_pc, s_ac, s_de, s_halt};
  endfunction

  // One clock with the given inputs, then model update and full output comparison.
  task automatic step(input bit r, input bit e, input logic [2:0] op, input bit z);
    logic [8:0] exp_s;
    rst = r; en = e; opcode = op; zero = z;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_halted = 1'b0;
    end else if (e && !m_halted) begin
      if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
    exp_s = expect_strobes(m_phase, m_halted, int'(op), z);
    check("phase",  16'(phase),  16'(m_phase));
    check("halted", 16'(halted), 16'(m_halted));
    check("strobes", 16'({sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}), 16'(exp_s));
    check("rd_and_data_e", 16'(rd & data_e), 16'd0);
    check("wr_without_data_e", 16'(wr & ~data_e), 16'd0);
  endtask

  initial begin
    logic [2:0] cur_op;
    rst = 1'b1; en = 1'b1; opcode = 3'd0; zero = 1'b0;

    // Reset for two clocks, then directed instruction walks.
    step(1, 1, 3'd0, 0);
    step(1, 1, 3'd0, 0);
    check("reset_sel", 16'(sel), 16'd1);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd5, 1'($urandom_range(0, 1)));
    check("lda_wrap_phase", 16'(phase), 16'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd6, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd7, 0);

    // HLT: stuck at phase 4 until reset.
    for (int i = 0; i < 12; i++) step(0, 1, 3'd0, 0);
    check("hlt_phase", 16'(phase), 16'd4);
    check("hlt_flag", 16'(halted), 16'd1);
    step(1, 1, 3'd0, 0);
    check("hlt_reset_phase", 16'(phase), 16'd0);

    // Freeze at phase 2, then reset mid-instruction at phase 6.
    step(0, 1, 3'd2, 0);
    step(0, 1, 3'd2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 3'd2, 0);
    check("freeze_ld_ir", 16'(ld_ir), 16'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd6, 0);
    check("at_phase6", 16'(phase), 16'd6);
    step(1, 1, 3'd6, 0);
    check("mid_reset_wr", 16'(wr | data_e), 16'd0);

    // Random traffic; opcode only changes at instruction boundaries.
    cur_op = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      if (m_phase == 0) cur_op = 3'($urandom_range(0, 7));
      r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 4) != 0);
      step(r, e, cur_op, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
